// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: walks one active-low digit select per
// DWELL cycles and drives the decoded, blanked and blinked segment pattern.
module seg_scan_driver #(
  parameter int NDIG      = 8,
  parameter int DWELL     = 4,
  parameter int BLINK_DIV = 1024
) (
  input  logic                fs,
  input  logic                rst,
  input  logic [4*NDIG-1:0]   digits,
  input  logic [NDIG-1:0]     dp,
  input  logic [NDIG-1:0]     blink_en,
  input  logic                blank_lz,
  output logic [NDIG-1:0]     led_dig,
  output logic [7:0]          display
);

  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W = $clog2(NDIG);
  localparam int BL_W  = $clog2(BLINK_DIV);

  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);
  localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_DIV - 1);

  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BL_W-1:0]  blink_q, blink_d;
  logic             phase_q, phase_d;
  logic [NDIG-1:0]  led_q, led_d;
  logic [7:0]       disp_q, disp_d;
  logic [3:0]       code;
  logic             lz_blank;

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0:    seg7 = 7'b0111111;
      4'h1:    seg7 = 7'b0000110;
      4'h2:    seg7 = 7'b1011011;
      4'h3:    seg7 = 7'b1001111;
      4'h4:    seg7 = 7'b1100110;
      4'h5:    seg7 = 7'b1101101;
      4'h6:    seg7 = 7'b1111101;
      4'h7:    seg7 = 7'b0000111;
      4'h8:    seg7 = 7'b1111111;
      4'h9:    seg7 = 7'b1101111;
      4'hA:    seg7 = 7'b1000000;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    dwell_d = dwell_q + 1'b1;
    idx_d   = idx_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Blink timebase is free-running and never touches the scan counters.
    blink_d = blink_q + 1'b1;
    phase_d = phase_q;
    if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end

    led_d        = '1;
    led_d[idx_q] = 1'b0;

    // Leading zero: this nibble and all above it are zero, i.e. shifting the
    // word down to this position leaves nothing.
    code     = digits[{idx_q, 2'b00} +: 4];
    lz_blank = blank_lz && (idx_q != '0) && ((digits >> {idx_q, 2'b00}) == '0);
    disp_d   = {dp[idx_q], seg7(code)};
    if (lz_blank || (phase_q && blink_en[idx_q]))
      disp_d = 8'h00;
  end

  always_ff @(posedge fs) begin
    if (rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      led_q   <= '1;
      disp_q  <= 8'h00;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      disp_q  <= disp_d;
    end
  end

  assign led_dig = led_q;
  assign display = disp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: vector table, corner sequences and
// randomized traffic against a cycle-count based reference model.
module tb_seg_scan_driver;
  localparam int NDIG = 8, DWELL = 4, BLINK_DIV = 16;

  logic        fs = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0]  dp = '0, blink_en = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  led_dig, display;

  int errors = 0, checks = 0;
  int n = 0;         // non-reset edges since the last reset edge
  int last_pos = 0;  // position the model expects on the outputs now

  seg_scan_driver #(.NDIG(NDIG), .DWELL(DWELL), .BLINK_DIV(BLINK_DIV)) dut (
    .fs(fs), .rst(rst), .digits(digits), .dp(dp), .blink_en(blink_en),
    .blank_lz(blank_lz), .led_dig(led_dig), .display(display)
  );

  always #5 fs = ~fs;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  be;
    logic        blz;
    int          pos;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
      4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
      4'h9: return 7'h6F;  4'hA: return 7'h40;  default: return 7'h00;
    endcase
  endfunction

  // Display expected for the output produced by the edge after n_ run edges.
  function automatic logic [7:0] model_disp(input int n_, input logic [31:0] d,
                                            input logic [7:0] p, input logic [7:0] be,
                                            input logic blz);
    int pos, ph;
    bit blanked;
    pos = (n_ / DWELL) % NDIG;
    ph  = (n_ / BLINK_DIV) % 2;
    blanked = 1'b0;
    if (blz && pos != 0) begin
      blanked = 1'b1;
      for (int q = pos; q < NDIG; q++)
        if (((d >> (4 * q)) & 32'hF) != 0) blanked = 1'b0;
    end
    if (blanked || (ph == 1 && be[pos])) return 8'h00;
    return {p[pos], seg_of(4'((d >> (4 * pos)) & 32'hF))};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [7:0] el, ed;
    @(posedge fs);
    if (rst) begin
      el = 8'hFF; ed = 8'h00; n = 0; last_pos = -1;
    end else begin
      last_pos = (n / DWELL) % NDIG;
      el = ~(8'd1 << last_pos);
      ed = model_disp(n, digits, dp, blink_en, blank_lz);
      n++;
    end
    #1;
    check8("model_led", led_dig, el);
    check8("model_display", display, ed);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 0, 8'h3F});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 1, 8'h06});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2, 8'h5B});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 3, 8'h4F});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 4, 8'h66});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 5, 8'h6D});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 6, 8'h7D});
    tbl.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 7, 8'h07});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b1, 7, 8'h00});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b1, 4, 8'h00});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b1, 3, 8'h40});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b1, 2, 8'h06});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b1, 1, 8'h3F});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b1, 0, 8'h6D});
    tbl.push_back('{32'h0000A105, 8'h00, 8'h00, 1'b0, 7, 8'h3F});
    tbl.push_back('{32'h00000000, 8'h00, 8'h00, 1'b1, 0, 8'h3F});
    tbl.push_back('{32'h00000000, 8'h00, 8'h00, 1'b1, 5, 8'h00});
    tbl.push_back('{32'h00000000, 8'h00, 8'h00, 1'b0, 5, 8'h3F});
    tbl.push_back('{32'h76543210, 8'h04, 8'h03, 1'b0, 2, 8'hDB});
    tbl.push_back('{32'h76543210, 8'h04, 8'h03, 1'b0, 0, 8'h3F});
    tbl.push_back('{32'h76543210, 8'h00, 8'hFF, 1'b0, 4, 8'h00});
    tbl.push_back('{32'h76543210, 8'h00, 8'hFF, 1'b0, 3, 8'h4F});
    tbl.push_back('{32'h76543210, 8'h00, 8'hC0, 1'b0, 6, 8'h00});
    tbl.push_back('{32'h89ABCDEF, 8'h00, 8'h00, 1'b0, 0, 8'h00});
    tbl.push_back('{32'h89ABCDEF, 8'h00, 8'h00, 1'b0, 5, 8'h40});
    tbl.push_back('{32'h89ABCDEF, 8'h00, 8'h00, 1'b0, 6, 8'h6F});
    tbl.push_back('{32'h89ABCDEF, 8'h00, 8'h00, 1'b0, 7, 8'h7F});
    tbl.push_back('{32'h00000001, 8'hFF, 8'h00, 1'b1, 7, 8'h00});
    tbl.push_back('{32'h00000001, 8'hFF, 8'h00, 1'b1, 0, 8'h86});

    // Reset state
    step(); step();
    check8("reset_led", led_dig, 8'hFF);
    check8("reset_display", display, 8'h00);

    // Vector table: reset, apply inputs, run until the position is shown
    foreach (tbl[i]) begin
      do_reset();
      digits = tbl[i].d; dp = tbl[i].p; blink_en = tbl[i].be; blank_lz = tbl[i].blz;
      for (int k = 0; k < 2 * NDIG * DWELL; k++) begin
        step();
        if (last_pos == tbl[i].pos) break;
      end
      check8($sformatf("vec%0d_pos", i), 8'(last_pos), 8'(tbl[i].pos));
      check8($sformatf("vec%0d_display", i), display, tbl[i].exp);
    end

    // Frame walk: each select lasts exactly DWELL cycles, frame wraps
    do_reset();
    digits = 32'h76543210; dp = '0; blink_en = '0; blank_lz = 1'b0;
    for (int k = 0; k < NDIG * DWELL + DWELL; k++) begin
      step();
      check8("walk_led", led_dig, ~(8'd1 << ((k / DWELL) % NDIG)));
    end

    // Reset mid-scan at idx=5, dwell count 2
    do_reset();
    repeat (22) step();
    check8("midrst_pre_led", led_dig, 8'hDF);
    rst = 1'b1; step(); rst = 1'b0;
    check8("midrst_led", led_dig, 8'hFF);
    check8("midrst_display", display, 8'h00);
    for (int k = 0; k < DWELL; k++) begin
      step();
      check8("midrst_hold_led", led_dig, 8'hFE);
    end
    step();
    check8("midrst_next_led", led_dig, 8'hFD);

    // Digit change mid-dwell on position 0
    do_reset();
    digits = 32'h00000001;
    step(); step();
    check8("chg_before", display, 8'h06);
    digits = 32'h00000009;
    step();
    check8("chg_after", display, 8'h6F);
    check8("chg_led", led_dig, 8'hFE);
    step();
    check8("chg_led_hold", led_dig, 8'hFE);
    step();
    check8("chg_led_next", led_dig, 8'hFD);

    // Long blink run across several half-periods
    do_reset();
    digits = 32'h76543210; dp = 8'h04; blink_en = 8'h33;
    repeat (4 * NDIG * DWELL) step();

    // Randomized traffic, occasional resets
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int q = 0; q < NDIG; q++)
          digits[4*q +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dp = 8'($urandom); blink_en = 8'($urandom); blank_lz = 1'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
